sb_bus_arbiter: RTL
===================

# sb_bus_arbiter

Shares the single system-bus port of the SB_SPI hard IP among up to NREQ requesters, such as the Z80 bridge and the SPI poll engine. After reset it runs the fixed SPI configuration write sequence, then grants bus transactions round-robin. It owns `sbstb`/`sbrw`/`sbadr`/`sbdati` and returns `sbdato` to the winning requester. It sits directly between the Z80-side logic and `SB_SPI`, clocked by the `SB_HFOSC` `clk`.

## Interface
- NREQ, 2: number of requesters (1–4).
- TIMEOUT_CYCLES, 255: cycles to wait for `sback` before abort (only used with `SB_ARB_TIMEOUT_EN`).
- clk  in  1  system clock (`SB_HFOSC` output); all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  requester i has a pending transaction; held until its `req_done[i]`.
- req_rw  in  NREQ  1 = write (`SB_WR`), 0 = read.
- req_adr  in  8*NREQ  register address, slice [8i+7:8i].
- req_wdat  in  8*NREQ  write data, slice [8i+7:8i].
- req_done  out  NREQ  one-cycle pulse: requester i's transaction finished.
- rsp_dat  out  8  `sbdato` captured on ack; valid in the `req_done` cycle.
- rsp_err  out  1  qualifies `req_done`: timeout abort (always 0 without the macro).
- init_done  out  1  high once the config sequence is complete; stays high until `rst`.
- sbstb, sbrw  out  1 each  to `SB_SPI` SBSTBI / SBRWI.
- sbadr, sbdati  out  8 each  to SBADRI / SBDATI.
- sbdato  in  8  from SBDATO.
- sback  in  1  from SBACKO.

## Operation
- Reset values: `sbstb`=0, `sbrw`=0, `sbadr`=0, `sbdati`=0, `req_done`=0, `rsp_dat`=0, `rsp_err`=0, `init_done`=0. Round-robin pointer=0, state=INIT, init index=0.
- Init table, writes in order: 0x08←0x00, 0x09←0x80, 0x0A←0x01, 0x0B←0x00, 0x0F←0x00.
- States:
  - INIT: drive table entry, `sbstb`=1, go to INIT_WAIT.
  - INIT_WAIT: on `sback`, drop `sbstb` and advance the index. After the fifth ack, set `init_done`=1 and go to IDLE; otherwise go to INIT.
  - IDLE: if any `req_valid`, pick the first valid index starting at pointer (ascending, wrapping at NREQ). Latch its rw/adr/wdat onto the bus, `sbstb`=1, record the grant, go to ACCESS.
  - ACCESS: on `sback`, drop `sbstb`, capture `rsp_dat`←`sbdato` (also on writes), pulse `req_done[g]`, set pointer←(g+1) mod NREQ, go to IDLE.
- Requests are ignored while `init_done`=0; `req_done` never pulses during init.
- Bus address/data/rw are stable for the whole time `sbstb` is high.
- A requester dropping `req_valid` mid-transaction does not abort it; `req_done` still pulses.
- `sback` seen while `sbstb`=0 is ignored.

## Timing
- IDLE with request at cycle N → `sbstb` high at N+1.
- `sback` at cycle M → `sbstb` low and `req_done` at M+1.
- IDLE is revisited for at least one cycle between transactions: `sbstb` is low for ≥1 cycle between strobes, which the SB_SPI handshake requires.
- Minimum transaction period: ack latency + 2 cycles.
- Simultaneous requests: the lowest index at or after the pointer wins. The loser keeps `req_valid` and is served next.
- `rst` mid-transaction: the bus is released the next cycle (`sbstb`=0) and the init sequence restarts from entry 0. An in-flight requester gets no `req_done`.
- `init_done` rises in the same cycle `sbstb` drops after the fifth init ack.

## Configuration
- `SB_ARB_TIMEOUT_EN` defined:
  - A counter runs while in INIT_WAIT/ACCESS; it clears on every strobe start.
  - When the count reaches TIMEOUT_CYCLES without `sback`: drop `sbstb`, pulse `req_done[g]` with `rsp_err`=1 and `rsp_dat` unchanged, advance the pointer, go to IDLE.
  - During init, a timeout skips to the next table entry. `init_done` still rises after entry 5.
- Undefined: no counter; waits indefinitely for `sback`; `rsp_err` is tied 0.

## Test plan
- Reset release → five strobes with (adr,dat) = (08,00),(09,80),(0A,01),(0B,00),(0F,00), all `sbrw`=1; `init_done`=1 after the fifth ack.
- Post-init, requester 0 reads 0x0C, model acks after 3 cycles with `sbdato`=0x10 → `sbstb` high 1 cycle after request; `req_done[0]` with `rsp_dat`=0x10 one cycle after ack.
- Requesters 0 and 1 both valid continuously → grants alternate 0,1,0,1; `sbstb` low ≥1 cycle between strobes.
- Requester 1 writes 0x0D←0x5A while requester 0 is mid-transaction → 1 is granted only after `req_done[0]`; bus shows adr 0D, dat 5A, `sbrw`=1.
- `rst` asserted while ACCESS awaits ack → `sbstb`=0 next cycle, no `req_done`, and the init sequence replays from 0x08.
- With `SB_ARB_TIMEOUT_EN`, TIMEOUT_CYCLES=8, no ack → `req_done` with `rsp_err`=1 after 8 cycles, and the next requester is served.

Source files
------------

// File: rtl/sb_bus_arbiter_if.sv
// Bundles the requester-side and SB_SPI-side signals of sb_bus_arbiter.
// master: the arbiter itself; slave: the requesters plus the SB_SPI hard IP.
interface sb_bus_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_rw;
    logic [8*NREQ-1:0] req_adr;
    logic [8*NREQ-1:0] req_wdat;
    logic [NREQ-1:0]   req_done;
    logic [7:0]        rsp_dat;
    logic              rsp_err;
    logic              init_done;
    logic              sbstb;
    logic              sbrw;
    logic [7:0]        sbadr;
    logic [7:0]        sbdati;
    logic [7:0]        sbdato;
    logic              sback;

    modport master (
        input  req_valid, req_rw, req_adr, req_wdat, sbdato, sback,
        output req_done, rsp_dat, rsp_err, init_done, sbstb, sbrw, sbadr, sbdati
    );

    modport slave (
        output req_valid, req_rw, req_adr, req_wdat, sbdato, sback,
        input  req_done, rsp_dat, rsp_err, init_done, sbstb, sbrw, sbadr, sbdati
    );
endinterface

// File: rtl/sb_bus_arbiter.sv
// Round-robin arbiter for the SB_SPI system-bus port; runs the SPI config writes after reset.
// Optional ack timeout enabled by defining SB_ARB_TIMEOUT_EN.
module sb_bus_arbiter #(
    parameter int NREQ           = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic              clk,
    input logic              rst,
    sb_bus_arbiter_if.master bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] ST_INIT      = 2'd0;
    localparam logic [1:0] ST_INIT_WAIT = 2'd1;
    localparam logic [1:0] ST_IDLE      = 2'd2;
    localparam logic [1:0] ST_ACCESS    = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   grant_q, grant_d;
    logic            sbstb_q, sbstb_d;
    logic            sbrw_q, sbrw_d;
    logic [7:0]      sbadr_q, sbadr_d;
    logic [7:0]      sbdati_q, sbdati_d;
    logic [7:0]      rsp_dat_q, rsp_dat_d;
    logic [NREQ-1:0] req_done_q, req_done_d;
    logic            rsp_err_q, rsp_err_d;
    logic            init_done_q, init_done_d;

    logic [7:0]      init_adr, init_dat;
    logic            pick_found;
    logic [PW-1:0]   pick, cand, grant_next;
    logic            sel_rw;
    logic [7:0]      sel_adr, sel_wdat;
    logic            timeout;

    always_comb begin
        init_adr = 8'h08;
        init_dat = 8'h00;
        case (idx_q)
            3'd0:    begin init_adr = 8'h08; init_dat = 8'h00; end
            3'd1:    begin init_adr = 8'h09; init_dat = 8'h80; end
            3'd2:    begin init_adr = 8'h0A; init_dat = 8'h01; end
            3'd3:    begin init_adr = 8'h0B; init_dat = 8'h00; end
            default: begin init_adr = 8'h0F; init_dat = 8'h00; end
        endcase
    end

    // Scan downward from the farthest candidate so the closest valid index at/after ptr wins.
    always_comb begin
        pick_found = 1'b0;
        pick       = ptr_q;
        cand       = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = PW'((int'(ptr_q) + k) % NREQ);
            if (bus.req_valid[cand]) begin
                pick_found = 1'b1;
                pick       = cand;
            end
        end
    end

    always_comb begin
        sel_rw   = 1'b0;
        sel_adr  = 8'h00;
        sel_wdat = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (PW'(i) == pick) begin
                sel_rw   = bus.req_rw[i];
                sel_adr  = bus.req_adr[8*i +: 8];
                sel_wdat = bus.req_wdat[8*i +: 8];
            end
        end
    end

    assign grant_next = (grant_q == PW'(NREQ - 1)) ? '0 : grant_q + 1'b1;

`ifdef SB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Held at zero outside the wait states, so every new strobe starts a fresh count.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_INIT || state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(TIMEOUT_CYCLES)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cycles;

    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout               = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        sbstb_d     = sbstb_q;
        sbrw_d      = sbrw_q;
        sbadr_d     = sbadr_q;
        sbdati_d    = sbdati_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = 1'b0;
        req_done_d  = '0;
        init_done_d = init_done_q;
        case (state_q)
            ST_INIT: begin
                sbstb_d  = 1'b1;
                sbrw_d   = 1'b1;
                sbadr_d  = init_adr;
                sbdati_d = init_dat;
                state_d  = ST_INIT_WAIT;
            end
            ST_INIT_WAIT: begin
                if (bus.sback || timeout) begin
                    sbstb_d = 1'b0;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd4) begin
                        init_done_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        state_d = ST_INIT;
                    end
                end
            end
            ST_IDLE: begin
                if (pick_found) begin
                    sbstb_d  = 1'b1;
                    sbrw_d   = sel_rw;
                    sbadr_d  = sel_adr;
                    sbdati_d = sel_wdat;
                    grant_d  = pick;
                    state_d  = ST_ACCESS;
                end
            end
            default: begin
                if (bus.sback || timeout) begin
                    sbstb_d             = 1'b0;
                    req_done_d[grant_q] = 1'b1;
                    if (bus.sback) begin
                        rsp_dat_d = bus.sbdato;
                    end else begin
                        rsp_err_d = 1'b1;
                    end
                    ptr_d   = grant_next;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            idx_q       <= 3'd0;
            ptr_q       <= '0;
            grant_q     <= '0;
            sbstb_q     <= 1'b0;
            sbrw_q      <= 1'b0;
            sbadr_q     <= 8'h00;
            sbdati_q    <= 8'h00;
            rsp_dat_q   <= 8'h00;
            rsp_err_q   <= 1'b0;
            req_done_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            sbstb_q     <= sbstb_d;
            sbrw_q      <= sbrw_d;
            sbadr_q     <= sbadr_d;
            sbdati_q    <= sbdati_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            req_done_q  <= req_done_d;
            init_done_q <= init_done_d;
        end
    end

    assign bus.sbstb     = sbstb_q;
    assign bus.sbrw      = sbrw_q;
    assign bus.sbadr     = sbadr_q;
    assign bus.sbdati    = sbdati_q;
    assign bus.rsp_dat   = rsp_dat_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.req_done  = req_done_q;
    assign bus.init_done = init_done_q;
endmodule
